// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command-driven load/alu/store sequencer for the 12-bit-address memory port
module alu_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 8,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [3:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_src_a,
    input  logic [ADDR_W-1:0] i_cmd_src_b,
    input  logic              i_cmd_use_imm,
    input  logic [DATA_W-1:0] i_cmd_imm,
    input  logic [ADDR_W-1:0] i_cmd_dst,
    input  logic [LEN_W-1:0]  i_cmd_len,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [3:0]        o_alu_opcode,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_carry,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_carry_any
);

    // The memory samples re/addr at the end of RD_x and presents data READ_LAT
    // edges later; the wait state therefore spans READ_LAT+1 cycles and the
    // operand is captured on its final edge.
    localparam int LAT_W = $clog2(READ_LAT + 2);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_WT_A,
        S_RD_B,
        S_WT_B,
        S_EXEC,
        S_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_use_imm;
    logic [ADDR_W-1:0] r_a_ptr;
    logic [ADDR_W-1:0] r_b_ptr;
    logic [ADDR_W-1:0] r_d_ptr;
    logic [LEN_W-1:0]  r_count;
    logic [LAT_W-1:0]  r_lat;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_op;
    logic              r_carry_any;

    logic w_accept;
    logic w_lat_last;
    logic w_last_elem;

    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
    assign w_lat_last  = (r_lat == LAT_LAST);
    assign w_last_elem = (r_count == LEN_W'(1));

    // Strobes decode straight from the state register so reset clears them at once
    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_mem_re     = (r_state == S_RD_A) || (r_state == S_RD_B);
    assign o_mem_we     = (r_state == S_WR);
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_opcode = r_alu_op;
    assign o_carry_any  = r_carry_any;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the B read pair is skipped for immediate commands
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (i_cmd_len == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: w_next = S_WT_A;
            S_WT_A: begin
                if (w_lat_last) begin
                    w_next = r_use_imm ? S_EXEC : S_RD_B;
                end
            end
            S_RD_B: w_next = S_WT_B;
            S_WT_B: begin
                if (w_lat_last) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: w_next = S_WR;
            S_WR:   w_next = w_last_elem ? S_DONE : S_RD_A;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read-latency counter, running only inside the wait states
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lat <= '0;
        end else if ((r_state == S_WT_A) || (r_state == S_WT_B)) begin
            r_lat <= w_lat_last ? '0 : r_lat + LAT_W'(1);
        end else begin
            r_lat <= '0;
        end
    end

    // Command latch, element counter and address pointers (wrap modulo 2^ADDR_W)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_use_imm <= 1'b0;
            r_a_ptr   <= '0;
            r_b_ptr   <= '0;
            r_d_ptr   <= '0;
            r_count   <= '0;
            r_alu_op  <= '0;
        end else if (w_accept) begin
            r_use_imm <= i_cmd_use_imm;
            r_a_ptr   <= i_cmd_src_a;
            r_b_ptr   <= i_cmd_src_b;
            r_d_ptr   <= i_cmd_dst;
            r_count   <= i_cmd_len;
            r_alu_op  <= i_cmd_op;
        end else if (r_state == S_WR) begin
            r_a_ptr <= r_a_ptr + ADDR_W'(1);
            r_b_ptr <= r_b_ptr + ADDR_W'(1);
            r_d_ptr <= r_d_ptr + ADDR_W'(1);
            r_count <= r_count - LEN_W'(1);
        end
    end

    // ALU operand capture and sticky carry accumulation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_carry_any <= 1'b0;
        end else begin
            if (w_accept) begin
                r_carry_any <= 1'b0;
                if (i_cmd_use_imm) begin
                    r_alu_b <= i_cmd_imm;
                end
            end
            if ((r_state == S_WT_A) && w_lat_last) begin
                r_alu_a <= i_mem_rdata;
            end
            if ((r_state == S_WT_B) && w_lat_last) begin
                r_alu_b <= i_mem_rdata;
            end
            if (r_state == S_EXEC) begin
                r_carry_any <= r_carry_any | i_alu_carry;
            end
        end
    end

    // Memory address/data: loaded one cycle ahead of each strobe, held otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept && (i_cmd_len != '0)) begin
                r_mem_addr <= i_cmd_src_a;
            end
            if ((r_state == S_WT_A) && w_lat_last && !r_use_imm) begin
                r_mem_addr <= r_b_ptr;
            end
            if (r_state == S_EXEC) begin
                r_mem_addr  <= r_d_ptr;
                r_mem_wdata <= i_alu_result;
            end
            if ((r_state == S_WR) && !w_last_elem) begin
                r_mem_addr <= r_a_ptr + ADDR_W'(1);
            end
        end
    end

endmodule
